// File: rtl/ext_nand_page_reader.sv
// ext_nand_page_reader: reads LEN bytes from a NAND device once R/B reports
// ready. Each byte takes three clocks: RE1 is low for two clocks, then high
// for one. An optional R/B timeout is compiled in when the macro
// EXT_NAND_RB_TIMEOUT_EN is defined. Without it, TOUT is tied low.
module ext_nand_page_reader #(
    parameter int unsigned TWB        = 4,
    parameter int unsigned RB_TIMEOUT = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENA,
    input  logic [11:0] LEN,
    input  logic        RB,
    input  logic [7:0]  IO,
    output logic        RE1,
    output logic [7:0]  DOUT,
    output logic        DVALID,
    output logic        COMPLT,
    output logic        TOUT
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WB_DLY   = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_RE_L1    = 3'd3;
    localparam logic [2:0] S_RE_L2    = 3'd4;
    localparam logic [2:0] S_RE_H     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam int unsigned DLY_W = (TWB > 0) ? $clog2(TWB + 1) : 1;

    logic              rb_meta_q;
    logic              rb_sync_q;
    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [11:0]       cnt_q;
    logic [11:0]       cnt_d;
    logic [DLY_W-1:0]  dly_q;
    logic [DLY_W-1:0]  dly_d;
    logic              re1_q;
    logic              re1_d;
    logic [7:0]        dout_q;
    logic [7:0]        dout_d;
    logic              dvalid_q;
    logic              dvalid_d;
    logic              complt_q;
    logic              complt_d;

`ifdef EXT_NAND_RB_TIMEOUT_EN
    localparam int unsigned TO_W = (RB_TIMEOUT > 1) ? $clog2(RB_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RB_TIMEOUT - 1);

    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_d;
    logic              to_hit;
    logic              tout_q;
    logic              tout_d;
`endif

    // Two-flop synchronizer for the asynchronous ready/busy line
    always_ff @(posedge CLK) begin
        if (RST) begin
            rb_meta_q <= 1'b1;
            rb_sync_q <= 1'b1;
        end else begin
            rb_meta_q <= RB;
            rb_sync_q <= rb_meta_q;
        end
    end

    // Next-state and counter logic; a low ENA overrides every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
`ifdef EXT_NAND_RB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_hit   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ENA) begin
                    cnt_d = LEN;
`ifdef EXT_NAND_RB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (LEN == 12'd0) begin
                        state_d = S_DONE;
                    end else begin
                        dly_d   = DLY_W'(TWB);
                        state_d = S_WB_DLY;
                    end
                end
            end
            S_WB_DLY: begin
                // The cycle whose decrement brings the count to zero is the last one here
                if (dly_q <= DLY_W'(1)) begin
                    dly_d   = '0;
                    state_d = S_WAIT_RDY;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_WAIT_RDY: begin
                if (rb_sync_q) begin
                    state_d = S_RE_L1;
                end else begin
`ifdef EXT_NAND_RB_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        to_hit  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`endif
                end
            end
            S_RE_L1: state_d = S_RE_L2;
            S_RE_L2: state_d = S_RE_H;
            S_RE_H: begin
                cnt_d   = cnt_q - 12'd1;
                state_d = (cnt_q == 12'd1) ? S_DONE : S_RE_L1;
            end
            S_DONE: begin
                if (!ENA) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!ENA && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Outputs decoded from the next state so the registered pins line up with the state
    always_comb begin
        re1_d    = !((state_d == S_RE_L1) || (state_d == S_RE_L2));
        dvalid_d = (state_q == S_RE_L2) && (state_d == S_RE_H);
        dout_d   = dvalid_d ? IO : dout_q;
        complt_d = (state_d == S_DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dly_q    <= '0;
            re1_q    <= 1'b1;
            dout_q   <= 8'h00;
            dvalid_q <= 1'b0;
            complt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            re1_q    <= re1_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            complt_q <= complt_d;
        end
    end

`ifdef EXT_NAND_RB_TIMEOUT_EN
    // TOUT is set on a timeout entry into DONE and cleared when DONE is left
    always_comb begin
        tout_d = 1'b0;
        if (state_d == S_DONE) begin
            tout_d = (state_q == S_DONE) ? tout_q : to_hit;
        end
    end

    // Timeout counter and flag registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q <= '0;
            tout_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            tout_q   <= tout_d;
        end
    end

    assign TOUT = tout_q;
`else
    // No timeout logic in this build; RB_TIMEOUT stays in the parameter list
    // so both builds share one instantiation.
    localparam logic TOUT_CONST = (RB_TIMEOUT == 0) && 1'b0;

    assign TOUT = TOUT_CONST;
`endif

    assign RE1    = re1_q;
    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign COMPLT = complt_q;

endmodule

// File: tb/tb_ext_nand_page_reader.sv
// Scoreboard bench for ext_nand_page_reader. Expected bytes are queued when a
// transfer is started; bytes seen on DOUT with DVALID are queued by tick() and
// each test drains and compares both queues.
module tb_ext_nand_page_reader;

    localparam int unsigned TWB_P = 4;
    localparam int unsigned RBTO_P = 100;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [11:0] len;
    logic        rb;
    logic [7:0]  io;
    logic        re1;
    logic [7:0]  dout;
    logic        dvalid;
    logic        complt;
    logic        tout;

    int vectors;
    int errors;
    int cyc;
    int pulses;
    int strobes;
    int bad_width;
    int low_len;
    int src_idx;
    logic re1_prev;
    logic [7:0] src_mem [0:63];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int strobe_cyc [$];

    ext_nand_page_reader #(.TWB(TWB_P), .RB_TIMEOUT(RBTO_P)) dut (
        .CLK(clk), .RST(rst), .ENA(ena), .LEN(len), .RB(rb), .IO(io),
        .RE1(re1), .DOUT(dout), .DVALID(dvalid), .COMPLT(complt), .TOUT(tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; model the NAND data bus and record strobes.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!re1 && re1_prev) begin
            io = src_mem[src_idx % 64];
            src_idx++;
            pulses++;
            low_len = 1;
        end else if (!re1) begin
            low_len++;
        end else if (!re1_prev && low_len != 2) begin
            bad_width++;
        end
        re1_prev = re1;
        if (dvalid) begin
            strobes++;
            got_q.push_back(dout);
            strobe_cyc.push_back(cyc);
        end
    endtask

    task automatic push_expected(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(src_mem[(src_idx + k) % 64]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++; if (re1 !== 1'b1)    begin errors++; $display("FAIL reset_re1 got %b want 1", re1); end
        vectors++; if (dout !== 8'h00)  begin errors++; $display("FAIL reset_dout got %02h want 00", dout); end
        vectors++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b want 0", dvalid); end
        vectors++; if (complt !== 1'b0) begin errors++; $display("FAIL reset_complt got %b want 0", complt); end
        vectors++; if (tout !== 1'b0)   begin errors++; $display("FAIL reset_tout got %b want 0", tout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_read();
        int t0, first_low, n, s0, p0, complt_cyc;
        logic [7:0] got, want;
        src_mem[src_idx % 64] = 8'hA5;
        src_mem[(src_idx + 1) % 64] = 8'h5A;
        src_mem[(src_idx + 2) % 64] = 8'hC3;
        push_expected(3);
        strobe_cyc.delete();
        s0 = strobes; p0 = pulses; first_low = 0; n = 0;
        rb = 1'b1; len = 12'd3; ena = 1'b1; t0 = cyc;
        while (!complt && n < 200) begin
            tick(); n++;
            if (!re1 && first_low == 0) first_low = cyc - t0;
        end
        complt_cyc = cyc;
        vectors++; if (!complt) begin errors++; $display("FAIL basic_complt got 0 want 1 within 200 cycles"); end
        vectors++; if (first_low != 1 + TWB_P + 1) begin errors++; $display("FAIL basic_first_re1_low got cycle %0d want %0d", first_low, 1 + TWB_P + 1); end
        vectors++; if (strobes - s0 != 3) begin errors++; $display("FAIL basic_strobes got %0d want 3", strobes - s0); end
        vectors++; if (pulses - p0 != 3) begin errors++; $display("FAIL basic_re1_pulses got %0d want 3", pulses - p0); end
        if (strobe_cyc.size() == 3) begin
            vectors++; if (strobe_cyc[1] - strobe_cyc[0] != 3) begin errors++; $display("FAIL basic_gap01 got %0d want 3", strobe_cyc[1] - strobe_cyc[0]); end
            vectors++; if (strobe_cyc[2] - strobe_cyc[1] != 3) begin errors++; $display("FAIL basic_gap12 got %0d want 3", strobe_cyc[2] - strobe_cyc[1]); end
            vectors++; if (complt_cyc != strobe_cyc[2] + 1) begin errors++; $display("FAIL basic_complt_cycle got %0d want %0d", complt_cyc, strobe_cyc[2] + 1); end
        end
        while (got_q.size() > 0) begin
            got = got_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra_byte got %02h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL basic_dout got %02h want %02h", got, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d short want 0", exp_q.size()); exp_q.delete(); end
        repeat (3) tick();
        vectors++; if (complt !== 1'b1) begin errors++; $display("FAIL basic_complt_hold got %b want 1", complt); end
        ena = 1'b0;
        tick();
        vectors++; if (complt !== 1'b0) begin errors++; $display("FAIL basic_complt_clear got %b want 0", complt); end
        vectors++; if (bad_width != 0) begin errors++; $display("FAIL basic_re1_width got %0d bad want 0", bad_width); end
    endtask

    task automatic test_rb_wait();
        int lows, n, s0;
        logic [7:0] got, want;
        push_expected(2);
        s0 = strobes; lows = 0; n = 0;
        rb = 1'b0; len = 12'd2; ena = 1'b1;
        repeat (20) begin tick(); if (!re1) lows++; end
        vectors++; if (lows != 0) begin errors++; $display("FAIL rbwait_busy_re1 got %0d low cycles want 0", lows); end
        rb = 1'b1;
        tick();
        vectors++; if (re1 !== 1'b1) begin errors++; $display("FAIL rbwait_sync1 got %b want 1", re1); end
        tick();
        vectors++; if (re1 !== 1'b1) begin errors++; $display("FAIL rbwait_sync2 got %b want 1", re1); end
        tick();
        vectors++; if (re1 !== 1'b0) begin errors++; $display("FAIL rbwait_first_re1 got %b want 0", re1); end
        while (!complt && n < 100) begin tick(); n++; end
        vectors++; if (!complt) begin errors++; $display("FAIL rbwait_complt got 0 want 1 within 100 cycles"); end
        vectors++; if (strobes - s0 != 2) begin errors++; $display("FAIL rbwait_strobes got %0d want 2", strobes - s0); end
        while (got_q.size() > 0) begin
            got = got_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rbwait_extra_byte got %02h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL rbwait_dout got %02h want %02h", got, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL rbwait_missing got %0d short want 0", exp_q.size()); exp_q.delete(); end
        ena = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        int s0, p0, lows;
        s0 = strobes; p0 = pulses; lows = 0;
        len = 12'd0; ena = 1'b1;
        tick();
        if (!re1) lows++;
        tick();
        if (!re1) lows++;
        vectors++; if (complt !== 1'b1) begin errors++; $display("FAIL len0_complt got %b want 1", complt); end
        repeat (4) begin tick(); if (!re1) lows++; end
        vectors++; if (lows != 0) begin errors++; $display("FAIL len0_re1 got %0d low cycles want 0", lows); end
        vectors++; if (strobes - s0 != 0) begin errors++; $display("FAIL len0_strobes got %0d want 0", strobes - s0); end
        vectors++; if (pulses - p0 != 0) begin errors++; $display("FAIL len0_pulses got %0d want 0", pulses - p0); end
        ena = 1'b0;
        tick();
        vectors++; if (complt !== 1'b0) begin errors++; $display("FAIL len0_complt_clear got %b want 0", complt); end
    endtask

    task automatic test_abort();
        int n, s0;
        logic [7:0] got, want, fourth;
        fourth = src_mem[(src_idx + 3) % 64];
        push_expected(4);
        s0 = strobes; n = 0;
        rb = 1'b1; len = 12'd10; ena = 1'b1;
        while (strobes - s0 < 4 && n < 200) begin tick(); n++; end
        ena = 1'b0;
        tick();
        vectors++; if (re1 !== 1'b1)    begin errors++; $display("FAIL abort_re1 got %b want 1", re1); end
        vectors++; if (complt !== 1'b0) begin errors++; $display("FAIL abort_complt got %b want 0", complt); end
        vectors++; if (dvalid !== 1'b0) begin errors++; $display("FAIL abort_dvalid got %b want 0", dvalid); end
        vectors++; if (dout !== fourth) begin errors++; $display("FAIL abort_dout_hold got %02h want %02h", dout, fourth); end
        repeat (10) tick();
        vectors++; if (strobes - s0 != 4) begin errors++; $display("FAIL abort_strobes got %0d want 4", strobes - s0); end
        push_expected(1);
        len = 12'd1; ena = 1'b1; n = 0;
        while (!complt && n < 100) begin tick(); n++; end
        vectors++; if (!complt) begin errors++; $display("FAIL restart_complt got 0 want 1 within 100 cycles"); end
        vectors++; if (strobes - s0 != 5) begin errors++; $display("FAIL restart_strobes got %0d want 5", strobes - s0); end
        while (got_q.size() > 0) begin
            got = got_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL abort_extra_byte got %02h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL abort_dout got %02h want %02h", got, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing got %0d short want 0", exp_q.size()); exp_q.delete(); end
        ena = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n, s0;
        s0 = strobes; n = 0;
        rb = 1'b1; len = 12'd3; ena = 1'b1;
        while (re1 && n < 50) begin tick(); n++; end
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (re1 !== 1'b1)    begin errors++; $display("FAIL rstmid_re1 got %b want 1", re1); end
        vectors++; if (dout !== 8'h00)  begin errors++; $display("FAIL rstmid_dout got %02h want 00", dout); end
        vectors++; if (dvalid !== 1'b0) begin errors++; $display("FAIL rstmid_dvalid got %b want 0", dvalid); end
        vectors++; if (complt !== 1'b0) begin errors++; $display("FAIL rstmid_complt got %b want 0", complt); end
        vectors++; if (tout !== 1'b0)   begin errors++; $display("FAIL rstmid_tout got %b want 0", tout); end
        rst = 1'b0; ena = 1'b0;
        repeat (6) tick();
        vectors++; if (strobes - s0 != 0) begin errors++; $display("FAIL rstmid_strobes got %0d want 0", strobes - s0); end
        got_q.delete();
    endtask

    task automatic test_max_len();
        int n, s0;
        logic [7:0] got, want;
        push_expected(4095);
        s0 = strobes; n = 0;
        rb = 1'b1; len = 12'd4095; ena = 1'b1;
        tick();
        len = 12'd5;
        while (!complt && n < 13000) begin tick(); n++; end
        vectors++; if (!complt) begin errors++; $display("FAIL maxlen_complt got 0 want 1 within 13000 cycles"); end
        vectors++; if (strobes - s0 != 4095) begin errors++; $display("FAIL maxlen_strobes got %0d want 4095", strobes - s0); end
        while (got_q.size() > 0) begin
            got = got_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL maxlen_extra_byte got %02h want none", got); end
            else begin
                want = exp_q.pop_front();
                if (got !== want) begin errors++; $display("FAIL maxlen_dout got %02h want %02h", got, want); end
            end
        end
        vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL maxlen_missing got %0d short want 0", exp_q.size()); exp_q.delete(); end
        ena = 1'b0;
        tick();
    endtask

`ifdef EXT_NAND_RB_TIMEOUT_EN
    task automatic test_timeout();
        int n, p0;
        p0 = pulses; n = 0;
        rb = 1'b0; len = 12'd2; ena = 1'b1;
        while (!complt && n < 300) begin tick(); n++; end
        vectors++; if (!complt) begin errors++; $display("FAIL timeout_complt got 0 want 1 within 300 cycles"); end
        vectors++; if (n != 1 + TWB_P + RBTO_P) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", n, 1 + TWB_P + RBTO_P); end
        vectors++; if (tout !== 1'b1) begin errors++; $display("FAIL timeout_tout got %b want 1", tout); end
        vectors++; if (pulses - p0 != 0) begin errors++; $display("FAIL timeout_pulses got %0d want 0", pulses - p0); end
        ena = 1'b0;
        tick();
        vectors++; if (tout !== 1'b0) begin errors++; $display("FAIL timeout_tout_clear got %b want 0", tout); end
        rb = 1'b1;
        repeat (3) tick();
    endtask
`else
    task automatic test_timeout();
        int p0, highs;
        p0 = pulses; highs = 0;
        rb = 1'b0; len = 12'd1; ena = 1'b1;
        repeat (200) begin tick(); if (complt || tout) highs++; end
        vectors++; if (highs != 0) begin errors++; $display("FAIL notimeout_flags got %0d cycles high want 0", highs); end
        vectors++; if (pulses - p0 != 0) begin errors++; $display("FAIL notimeout_pulses got %0d want 0", pulses - p0); end
        ena = 1'b0;
        tick();
        rb = 1'b1;
        repeat (3) tick();
    endtask
`endif

    initial begin
        vectors = 0; errors = 0; cyc = 0; pulses = 0; strobes = 0;
        bad_width = 0; low_len = 0; src_idx = 0; re1_prev = 1'b1;
        for (int i = 0; i < 64; i++) src_mem[i] = 8'((i * 29 + 7) | 1);
        rst = 1'b1; ena = 1'b0; len = 12'd0; rb = 1'b1; io = 8'h00;
        test_reset();
        test_basic_read();
        test_rb_wait();
        test_len_zero();
        test_abort();
        test_reset_mid();
        test_max_len();
        test_timeout();
        vectors++; if (bad_width != 0) begin errors++; $display("FAIL re1_pulse_width got %0d bad pulses want 0", bad_width); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
